// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - state type, default parameters and width helper for run_ctrl
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE
    } run_state_t;

    localparam int DEF_NUM_PROGS = 3;
    localparam int DEF_PC_W      = 10;
    localparam int DEF_CYC_W     = 16;
    localparam logic [DEF_NUM_PROGS*DEF_PC_W-1:0] DEF_PROG_BASE = {10'd128, 10'd64, 10'd0};

    // A single program still needs a one-bit selector port.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// rtl/run_ctrl_sat_counter.sv - clearable up-counter that stops at a programmable limit
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - program launch / run / watchdog sequencer driving the core PC
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int                            NUM_PROGS = DEF_NUM_PROGS,
    parameter int                            PC_W      = DEF_PC_W,
    parameter int                            CYC_W     = DEF_CYC_W,
    parameter int unsigned                   MAX_CYC   = (2**CYC_W) - 1,
    parameter logic [NUM_PROGS*PC_W-1:0]     PROG_BASE = DEF_PROG_BASE,
    localparam int                           SEL_W     = sel_width(NUM_PROGS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] ProgSel,
    input  logic             Halt,
    input  logic             Stall,
    output logic             CountEn,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcLoadAddr,
    output logic             Ack,
    output logic             Busy,
    output logic             Timeout,
    output logic [CYC_W-1:0] CycCnt,
    output logic [SEL_W-1:0] ProgId
);

    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYC);
    localparam logic [CYC_W-1:0] WDOG_AT   = CYC_W'(MAX_CYC - 1);

    run_state_t       r_state;
    logic             r_stall_q;
    logic             r_pc_load;
    logic [PC_W-1:0]  r_pc_load_addr;
    logic             r_ack;
    logic             r_busy;
    logic             r_timeout;
    logic [SEL_W-1:0] r_prog_id;

    logic             w_sel_ok;
    logic             w_wdog;
    logic             w_cnt_clear;
    logic             w_cnt_en;
    logic [CYC_W-1:0] w_cyc_cnt;

    assign w_sel_ok    = (int'(ProgSel) < NUM_PROGS);
    assign w_wdog      = (w_cyc_cnt == WDOG_AT);
    // Any launch from ARMED (valid or not) starts the cycle count from zero.
    assign w_cnt_clear = (r_state == ARMED) && !Start;
    assign w_cnt_en    = (r_state == RUN);

    sat_counter #(
        .W (CYC_W)
    ) u_cyc_cnt (
        .i_clk    (Clk),
        .i_reset  (Reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .i_limit  (CYC_LIMIT),
        .o_count  (w_cyc_cnt)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= IDLE;
            r_stall_q      <= 1'b0;
            r_pc_load      <= 1'b0;
            r_pc_load_addr <= '0;
            r_ack          <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
            r_prog_id      <= '0;
        end else begin
            r_stall_q <= Stall;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!Start) begin
                        if (w_sel_ok) begin
                            r_state        <= LOAD;
                            r_prog_id      <= ProgSel;
                            r_pc_load      <= 1'b1;
                            r_pc_load_addr <= PROG_BASE[int'(ProgSel)*PC_W +: PC_W];
                            r_busy         <= 1'b1;
                        end else begin
                            r_state   <= DONE;
                            r_ack     <= 1'b1;
                            r_timeout <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    r_state        <= RUN;
                    r_pc_load      <= 1'b0;
                    r_pc_load_addr <= '0;
                end
                RUN: begin
                    // Exit priority: abort, then halt, then watchdog.
                    if (Start) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b0;
                    end else if (Halt) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                    end else if (w_wdog) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_ack     <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    if (Start) begin
                        r_state   <= ARMED;
                        r_ack     <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign CountEn    = (r_state == RUN) && !r_stall_q;
    assign PcLoad     = r_pc_load;
    assign PcLoadAddr = r_pc_load_addr;
    assign Ack        = r_ack;
    assign Busy       = r_busy;
    assign Timeout    = r_timeout;
    assign CycCnt     = w_cyc_cnt;
    assign ProgId     = r_prog_id;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed self-checking bench for run_ctrl with a completion scoreboard
module tb_run_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  ProgSel;
    logic        Halt;
    logic        Stall;
    logic        CountEn;
    logic        PcLoad;
    logic [9:0]  PcLoadAddr;
    logic        Ack;
    logic        Busy;
    logic        Timeout;
    logic [15:0] CycCnt;
    logic [1:0]  ProgId;

    typedef struct {
        logic [15:0] cyc;
        logic        tmo;
        logic [1:0]  prog;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    run_ctrl #(
        .NUM_PROGS (3),
        .PC_W      (10),
        .CYC_W     (16),
        .MAX_CYC   (100),
        .PROG_BASE ({10'd128, 10'd64, 10'd0})
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .ProgSel    (ProgSel),
        .Halt       (Halt),
        .Stall      (Stall),
        .CountEn    (CountEn),
        .PcLoad     (PcLoad),
        .PcLoadAddr (PcLoadAddr),
        .Ack        (Ack),
        .Busy       (Busy),
        .Timeout    (Timeout),
        .CycCnt     (CycCnt),
        .ProgId     (ProgId)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_counten"}, CountEn, 0);
        chk({tag, "_pcload"}, PcLoad, 0);
        chk({tag, "_pcaddr"}, PcLoadAddr, 0);
        chk({tag, "_ack"}, Ack, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_timeout"}, Timeout, 0);
        chk({tag, "_cyccnt"}, CycCnt, 0);
        chk({tag, "_progid"}, ProgId, 0);
    endtask

    task automatic push(input logic [15:0] c, input logic t, input logic [1:0] p);
        exp_t e;
        e.cyc  = c;
        e.tmo  = t;
        e.prog = p;
        sb.push_back(e);
    endtask

    // Start held for `hold` cycles, then released with `sel`; ends in the first RUN cycle.
    task automatic launch(input logic [1:0] sel, input logic [9:0] addr, input int hold);
        Start = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        chk("armed_busy", Busy, 0);
        chk("armed_ack", Ack, 0);
        Start   = 1'b0;
        ProgSel = sel;
        tick();
        chk("load_pcload", PcLoad, 1);
        chk("load_pcaddr", PcLoadAddr, addr);
        chk("load_busy", Busy, 1);
        chk("load_counten", CountEn, 0);
        chk("load_progid", ProgId, sel);
        chk("load_cyccnt", CycCnt, 0);
        tick();
        chk("run_pcload", PcLoad, 0);
        chk("run_pcaddr", PcLoadAddr, 0);
        chk("run_counten", CountEn, 1);
    endtask

    task automatic wait_done(input int bound, output int n);
        exp_t e;
        n = 0;
        while (Ack !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", Ack, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_cyccnt", CycCnt, e.cyc);
            chk("done_timeout", Timeout, e.tmo);
            chk("done_progid", ProgId, e.prog);
            chk("done_busy", Busy, 0);
            chk("done_counten", CountEn, 0);
            chk("done_pcload", PcLoad, 0);
        end
    endtask

    initial begin
        int n;
        int en_cnt;

        Reset   = 1'b1;
        Start   = 1'b0;
        Halt    = 1'b0;
        Stall   = 1'b0;
        ProgSel = 2'd0;
        tick();
        tick();
        chk_reset("rst");
        Reset = 1'b0;
        tick();
        tick();
        chk("idle_no_launch", Busy, 0);

        // Program 1, halt during the 20th RUN cycle.
        launch(2'd1, 10'd64, 3);
        en_cnt = 1;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (CountEn) en_cnt++;
        end
        chk("t1_cyc19", CycCnt, 19);
        chk("t1_en_cycles", en_cnt, 20);
        Halt = 1'b1;
        push(16'd20, 1'b0, 2'd1);
        wait_done(4, n);
        Halt = 1'b0;
        chk("t1_halt_lat", n, 1);
        tick();
        chk("t1_ack_held", Ack, 1);
        chk("t1_cyc_frozen", CycCnt, 20);

        // Program 2 with a five-cycle stall window.
        launch(2'd2, 10'd128, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("t2_cyc5", CycCnt, 5);
        Stall = 1'b1;
        chk("t2_stall_lag", CountEn, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_en", CountEn, 0);
        end
        chk("t2_cyc_adv", CycCnt, 10);
        Stall = 1'b0;
        tick();
        chk("t2_resume_en", CountEn, 1);
        chk("t2_cyc11", CycCnt, 11);
        Halt = 1'b1;
        push(16'd12, 1'b0, 2'd2);
        wait_done(4, n);
        Halt = 1'b0;

        // Program 0 runs into the watchdog.
        launch(2'd0, 10'd0, 1);
        push(16'd100, 1'b1, 2'd0);
        wait_done(150, n);
        chk("t3_wdog_cycles", n, 100);
        Start = 1'b1;
        tick();
        chk("t3_timeout_clr", Timeout, 0);
        chk("t3_ack_clr", Ack, 0);
        chk("t3_armed_frozen", CycCnt, 100);

        // Start and Halt together abort the run back to ARMED.
        launch(2'd1, 10'd64, 1);
        for (int i = 0; i < 4; i++) tick();
        Start = 1'b1;
        Halt  = 1'b1;
        tick();
        Halt = 1'b0;
        chk("t4_abort_ack", Ack, 0);
        chk("t4_abort_busy", Busy, 0);
        chk("t4_abort_en", CountEn, 0);
        chk("t4_abort_cyc", CycCnt, 5);
        tick();
        chk("t4_armed_cyc", CycCnt, 5);
        Start   = 1'b0;
        ProgSel = 2'd1;
        tick();
        chk("t4_relaunch_cyc", CycCnt, 0);
        chk("t4_relaunch_load", PcLoad, 1);
        tick();
        tick();
        tick();
        Halt = 1'b1;
        push(16'd3, 1'b0, 2'd1);
        wait_done(4, n);
        Halt = 1'b0;

        // Out-of-range program index goes straight to DONE.
        Start = 1'b1;
        tick();
        Start   = 1'b0;
        ProgSel = 2'd3;
        push(16'd0, 1'b0, 2'd1);
        wait_done(4, n);
        chk("t5_invalid_lat", n, 1);
        tick();
        chk("t5_no_pcload", PcLoad, 0);
        chk("t5_ack_held", Ack, 1);

        // Reset in the middle of a run.
        launch(2'd2, 10'd128, 1);
        tick();
        tick();
        tick();
        Stall = 1'b1;
        Reset = 1'b1;
        tick();
        chk_reset("mid");
        Reset = 1'b0;
        Stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_busy", Busy, 0);
            chk("post_rst_pcload", PcLoad, 0);
        end
        chk_reset("post");
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
